dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 SHALL have parameter MEM_WORDS, default 16, number of words in the data memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  2  per-requester access request, bit i = requester i.
REQ-006 SHALL have port we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 SHALL have port addr0, addr1  input  32 each  word address per requester.
REQ-008 SHALL have port wdata0, wdata1  input  32 each  write data per requester.
REQ-009 SHALL have port gnt  output  2  one-hot one-cycle grant pulse.
REQ-010 SHALL have port rspValid  output  2  one-hot one-cycle response pulse.
REQ-011 SHALL have port rspErr  output  1  response is an out-of-range error; valid only with rspValid.
REQ-012 SHALL have port rdata  output  32  read data; valid only with rspValid.
REQ-013 SHALL have port memAddr  output  32  address to the data memory.
REQ-014 SHALL have port memWriteData  output  32  write data to the data memory.
REQ-015 SHALL have ports memRead, memWrite  output  1 each  data-memory strobes.
REQ-016 SHALL have port memReadData  input  32  combinational read data from the data memory.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 In IDLE with any req bit set at a rising edge, SHALL latch the winner's index, we, addr and wdata, and enter ACCESS.
REQ-019 In ACCESS, SHALL assert gnt[winner] for exactly one cycle. Requesters hold req, we, addr and wdata stable until they see gnt.
REQ-020 In ACCESS with an in-range address (addr < MEM_WORDS), SHALL drive memAddr = latched addr and assert exactly one of memRead or memWrite (memWrite = latched we).
REQ-021 In ACCESS, SHALL drive memWriteData = latched wdata.
REQ-022 On a read, SHALL register memReadData into rdata at the end of ACCESS.
REQ-023 In RESP, SHALL assert rspValid[winner] for one cycle. On a write, rdata SHALL be 0.
REQ-024 Latency SHALL be fixed: req sampled at edge N gives gnt in cycle N+1 and rspValid in cycle N+2.
REQ-025 From RESP, SHALL go directly to ACCESS if any req bit is set at that edge (new arbitration), else to IDLE. Sustained throughput is therefore one access per 2 cycles.
REQ-026 Out-of-range address (addr >= MEM_WORDS): memRead and memWrite SHALL stay 0, and the RESP cycle SHALL give rspErr = 1 with rdata = 0.
REQ-027 Outside ACCESS, memRead and memWrite SHALL be 0 and memAddr and memWriteData SHALL be 0.
REQ-028 Both req bits set: SHALL grant according to REQ-035/036. The loser is not dropped and is served at the next arbitration.
REQ-029 A req deasserted before gnt (protocol violation) SHALL NOT corrupt the FSM. The latched access completes normally.

Reset
REQ-030 With reset = 1 at a rising edge, the FSM SHALL enter IDLE and abandon any in-flight access; no rspValid is issued for it.
REQ-031 During and after reset, gnt, rspValid, rspErr, rdata, memAddr, memWriteData, memRead and memWrite SHALL all be 0.
REQ-032 Reset SHALL set the round-robin last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-033 Reset asserted during ACCESS SHALL deassert memWrite in the following cycle; at most one memory write cycle occurs.

Configuration
REQ-034 Macro DMEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-035 With the macro defined, ties SHALL go to the requester not granted last; the pointer updates on every grant.
REQ-036 Without the macro, requester 0 SHALL always win ties (fixed priority) and no pointer state SHALL exist.

Verification
REQ-037 Reset, then req=01, we=0, addr0=5, memory[5]=5 -> gnt=01 at N+1, memRead=1 and memAddr=5 in ACCESS, rspValid=01, rdata=5, rspErr=0 at N+2.
REQ-038 req=10, we=10, addr1=9, wdata1=0xDEADBEEF -> memWrite=1 for exactly one cycle with memAddr=9, then rspValid=10 and rdata=0; a following read of 9 returns 0xDEADBEEF.
REQ-039 req=11 held for 4 accesses, round-robin build -> grant order 0,1,0,1; fixed-priority build with req0 always held -> 0,0,0,0.
REQ-040 req=01, addr0=16 -> no memRead/memWrite pulse; rspValid=01, rspErr=1, rdata=0.
REQ-041 reset=1 in the ACCESS cycle of a write -> no rspValid; all outputs 0 in the next cycle; FSM in IDLE.
REQ-042 req=01 held continuously -> rspValid pulses every 2 cycles; gnt never asserts while rspValid asserts for the same requester.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS (grant + memory strobe) -> RESP.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module dmem_arbiter #(
    parameter int NREQ      = 2,
    parameter int MEM_WORDS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    input  logic [31:0]     addr0,
    input  logic [31:0]     addr1,
    input  logic [31:0]     wdata0,
    input  logic [31:0]     wdata1,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rspValid,
    output logic            rspErr,
    output logic [31:0]     rdata,
    output logic [31:0]     memAddr,
    output logic [31:0]     memWriteData,
    output logic            memRead,
    output logic            memWrite,
    input  logic [31:0]     memReadData
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        win;
    logic        lat_win;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        in_range;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    // On a tie the requester that was not granted last wins.
    always_comb win = (req[0] && req[1]) ? ~last_gnt : ~req[0];
`else
    always_comb win = ~req[0];
`endif

    always_comb begin
        sel_addr  = win ? addr1  : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_we    = win ? we[1]  : we[0];
        in_range  = sel_addr < 32'(MEM_WORDS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_win      <= 1'b0;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            gnt          <= '0;
            rspValid     <= '0;
            rspErr       <= 1'b0;
            rdata        <= '0;
            memAddr      <= '0;
            memWriteData <= '0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_gnt     <= 1'b1;
`endif
        end else begin
            // Pulse outputs and memory bus default to idle every cycle.
            gnt          <= '0;
            rspValid     <= '0;
            rspErr       <= 1'b0;
            rdata        <= '0;
            memAddr      <= '0;
            memWriteData <= '0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            case (state)
                ACCESS: begin
                    rspValid <= NREQ'(1) << lat_win;
                    rspErr   <= lat_err;
                    rdata    <= (!lat_we && !lat_err) ? memReadData : '0;
                    state    <= RESP;
                end
                default: begin
                    // IDLE and RESP both arbitrate, giving one access per two cycles.
                    if (|req) begin
                        state        <= ACCESS;
                        lat_win      <= win;
                        lat_we       <= sel_we;
                        lat_err      <= !in_range;
                        gnt          <= NREQ'(1) << win;
                        memAddr      <= in_range ? sel_addr : '0;
                        memWriteData <= sel_wdata;
                        memRead      <= in_range && !sel_we;
                        memWrite     <= in_range && sel_we;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_gnt     <= win;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory and a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 16;

    typedef struct packed {
        logic [1:0]  vld;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, rspValid;
    logic        rspErr;
    logic [31:0] rdata, memAddr, memWriteData, memReadData;
    logic        memRead, memWrite;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    resp_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NREQ(2), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rspValid(rspValid), .rspErr(rspErr), .rdata(rdata),
        .memAddr(memAddr), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData)
    );

    assign memReadData = (memAddr < 32'(MEM_WORDS)) ? mem[memAddr[3:0]] : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (memWrite && memAddr < 32'(MEM_WORDS)) mem[memAddr[3:0]] <= memWriteData;

    task automatic launch(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[idx] = 1'b1;
        we[idx]  = w;
        if (idx == 0) begin addr0 = a; wdata0 = d; end
        else          begin addr1 = a; wdata1 = d; end
    endtask

    task automatic expect_resp(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        r.vld  = 2'b01 << idx;
        r.err  = (a >= 32'(MEM_WORDS));
        r.data = '0;
        if (!r.err) begin
            if (w) ref_mem[a[3:0]] = d;
            else   r.data = ref_mem[a[3:0]];
        end
        exp_q.push_back(r);
    endtask

    task automatic pop_exp(output resp_t r);
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: response seen with nothing expected");
            r = '0;
        end else begin
            r = exp_q.pop_front();
        end
    endtask

    task automatic wait_gnt(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; we = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({gnt, rspValid, rspErr, memRead, memWrite} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt, rspValid, rspErr, memRead, memWrite});
        end
        n_cmp++; if ({rdata, memAddr, memWriteData} !== 96'b0) begin
            n_bad++; $display("FAIL reset_data: got rdata=%h memAddr=%h memWriteData=%h want 0", rdata, memAddr, memWriteData);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({gnt, rspValid, memRead, memWrite} !== 6'b0) begin
            n_bad++; $display("FAIL post_reset_idle: got %b want 0", {gnt, rspValid, memRead, memWrite});
        end
    endtask

    task automatic test_read();
        bit ok; int cyc; resp_t r;
        launch(0, 1'b0, 32'd5, 32'd0); expect_resp(0, 1'b0, 32'd5, 32'd0);
        wait_gnt(ok, cyc);
        n_cmp++; if (!ok || cyc != 1) begin
            n_bad++; $display("FAIL read_latency: got %0d cycles (ok=%0d) want 1", cyc, ok);
        end
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL read_gnt: got %b want 01", gnt); end
        n_cmp++; if ({memRead, memWrite} !== 2'b10 || memAddr !== 32'd5) begin
            n_bad++; $display("FAIL read_bus: got rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=5", memRead, memWrite, memAddr);
        end
        req = '0;
        @(negedge clk);
        n_cmp++; if (rspValid !== 2'b01 || gnt !== 2'b00) begin
            n_bad++; $display("FAIL read_rsp: got rspValid=%b gnt=%b want 01/00", rspValid, gnt);
        end
        pop_exp(r);
        n_cmp++; if (rdata !== r.data || rspErr !== r.err) begin
            n_bad++; $display("FAIL read_data: got %h err=%b want %h err=%b", rdata, rspErr, r.data, r.err);
        end
        n_cmp++; if ({memRead, memAddr} !== 33'b0) begin
            n_bad++; $display("FAIL read_bus_idle: got rd=%b addr=%h want 0", memRead, memAddr);
        end
    endtask

    task automatic test_write();
        bit ok; int cyc; resp_t r;
        launch(1, 1'b1, 32'd9, 32'hDEADBEEF); expect_resp(1, 1'b1, 32'd9, 32'hDEADBEEF);
        wait_gnt(ok, cyc);
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL write_gnt: got %b want 10", gnt); end
        n_cmp++; if ({memRead, memWrite} !== 2'b01 || memAddr !== 32'd9 || memWriteData !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL write_bus: got rd=%b wr=%b addr=%0d wd=%h want 0/1/9/deadbeef", memRead, memWrite, memAddr, memWriteData);
        end
        req = '0;
        @(negedge clk);
        n_cmp++; if (memWrite !== 1'b0) begin n_bad++; $display("FAIL write_pulse_len: got memWrite=%b want 0", memWrite); end
        pop_exp(r);
        n_cmp++; if (rspValid !== r.vld || rdata !== r.data || rspErr !== r.err) begin
            n_bad++; $display("FAIL write_rsp: got v=%b d=%h e=%b want v=%b d=%h e=%b", rspValid, rdata, rspErr, r.vld, r.data, r.err);
        end
        launch(0, 1'b0, 32'd9, 32'd0); expect_resp(0, 1'b0, 32'd9, 32'd0);
        wait_gnt(ok, cyc);
        req = '0;
        @(negedge clk);
        pop_exp(r);
        n_cmp++; if (rspValid !== r.vld || rdata !== r.data) begin
            n_bad++; $display("FAIL write_readback: got v=%b d=%h want v=%b d=%h", rspValid, rdata, r.vld, r.data);
        end
    endtask

    task automatic test_out_of_range();
        int          t_idx  [6] = '{0, 1, 0, 1, 0, 1};
        logic        t_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_addr [6] = '{32'd16, 32'd20, 32'd15, 32'd15, 32'd15, 32'h8000_0005};
        logic [31:0] t_data [6] = '{32'd0, 32'h55AA55AA, 32'd0, 32'hCAFEF00D, 32'd0, 32'd0};
        for (int k = 0; k < 6; k++) begin
            bit ok; int cyc; resp_t r; logic inr;
            inr = t_addr[k] < 32'(MEM_WORDS);
            launch(t_idx[k], t_we[k], t_addr[k], t_data[k]);
            expect_resp(t_idx[k], t_we[k], t_addr[k], t_data[k]);
            wait_gnt(ok, cyc);
            n_cmp++; if (!ok || gnt !== (2'b01 << t_idx[k])) begin
                n_bad++; $display("FAIL range_gnt[%0d]: got %b want %b", k, gnt, 2'b01 << t_idx[k]);
            end
            n_cmp++; if ({memRead, memWrite} !== {inr && !t_we[k], inr && t_we[k]}) begin
                n_bad++; $display("FAIL range_strobe[%0d]: got rd=%b wr=%b want rd=%b wr=%b", k, memRead, memWrite, inr && !t_we[k], inr && t_we[k]);
            end
            req = '0;
            @(negedge clk);
            pop_exp(r);
            n_cmp++; if (rspValid !== r.vld || rspErr !== r.err || rdata !== r.data) begin
                n_bad++; $display("FAIL range_rsp[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", k, rspValid, rspErr, rdata, r.vld, r.err, r.data);
            end
        end
    endtask

    task automatic test_arbitration();
        int order [4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        do_reset();
        addr0 = 32'd2; addr1 = 32'd3; we = 2'b00; req = 2'b11;
        for (int k = 0; k < 4; k++)
            expect_resp(order[k], 1'b0, (order[k] == 1) ? 32'd3 : 32'd2, 32'd0);
        for (int k = 0; k < 4; k++) begin
            bit ok; int cyc; resp_t r;
            wait_gnt(ok, cyc);
            n_cmp++; if (!ok || gnt !== (2'b01 << order[k])) begin
                n_bad++; $display("FAIL arb_order[%0d]: got gnt=%b want %b", k, gnt, 2'b01 << order[k]);
            end
            if (k == 3) req = '0;
            @(negedge clk);
            pop_exp(r);
            n_cmp++; if (rspValid !== r.vld || rdata !== r.data) begin
                n_bad++; $display("FAIL arb_rsp[%0d]: got v=%b d=%h want v=%b d=%h", k, rspValid, rdata, r.vld, r.data);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok; int cyc; resp_t r; int seen;
        launch(0, 1'b1, 32'd7, 32'h0000_1234);
        wait_gnt(ok, cyc);
        n_cmp++; if (memWrite !== 1'b1) begin n_bad++; $display("FAIL abort_write_started: got memWrite=%b want 1", memWrite); end
        reset = 1'b1; req = '0;
        @(negedge clk);
        n_cmp++; if ({gnt, rspValid, rspErr, memRead, memWrite} !== 7'b0 || {rdata, memAddr, memWriteData} !== 96'b0) begin
            n_bad++; $display("FAIL abort_outputs: got ctrl=%b rdata=%h addr=%h wd=%h want 0",
                              {gnt, rspValid, rspErr, memRead, memWrite}, rdata, memAddr, memWriteData);
        end
        reset = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rspValid != 2'b00 || memWrite) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_rsp: got %0d active cycles want 0", seen); end
        launch(1, 1'b0, 32'd5, 32'd0); expect_resp(1, 1'b0, 32'd5, 32'd0);
        wait_gnt(ok, cyc);
        n_cmp++; if (!ok || cyc != 1 || gnt !== 2'b10) begin
            n_bad++; $display("FAIL abort_idle_latency: got %0d cycles gnt=%b want 1 cycle gnt=10", cyc, gnt);
        end
        req = '0;
        @(negedge clk);
        pop_exp(r);
        n_cmp++; if (rspValid !== r.vld || rdata !== r.data) begin
            n_bad++; $display("FAIL abort_recover_rsp: got v=%b d=%h want v=%b d=%h", rspValid, rdata, r.vld, r.data);
        end
    endtask

    task automatic test_back_to_back();
        resp_t r;
        @(negedge clk);
        launch(0, 1'b0, 32'd3, 32'd0);
        for (int k = 0; k < 4; k++) expect_resp(0, 1'b0, 32'd3, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt[0] !== (k % 2 == 1) || rspValid !== ((k % 2 == 0) ? 2'b01 : 2'b00)) begin
                n_bad++; $display("FAIL b2b_cycle[%0d]: got gnt=%b rspValid=%b want gnt0=%0d rsp0=%0d", k, gnt, rspValid, k % 2, 1 - k % 2);
            end
            if (rspValid[0]) begin
                pop_exp(r);
                n_cmp++; if (rdata !== r.data) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rdata, r.data);
                end
            end
            if (k == 8) req = '0;
        end
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b00 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_drain: got gnt=%b pending=%0d want 00/0", gnt, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = (i == 5) ? 32'd5 : 32'h1000_0000 + 32'(i) * 32'h111;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_read();
        test_write();
        test_out_of_range();
        test_arbitration();
        test_reset_mid_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
